// File: rtl/riscv_pkg.sv
// Shared RV32 load/store funct3 encodings, memory-stage FSM state and
// byte-lane helpers used by the memory stage.
package riscv_pkg;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (f3)
            F3_SB:   be = 4'b0001 << addr_lo;
            F3_SH:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Narrow stores replicate their data so every enabled lane sees it.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] wd;
        case (f3)
            F3_SB:   wd = {4{data[7:0]}};
            F3_SH:   wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

    // Load and store share funct3 codes for size, so one check covers both.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3)
            F3_LH, F3_LHU: mis = addr_lo[0];
            F3_LW:         mis = (addr_lo != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: selects the addressed byte/halfword lane of the bus
// word and sign- or zero-extends it according to funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte lane select.
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Halfword lane select; addr_lo[0] is ignored for halfwords.
    always_comb begin
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension by load type.
    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data = {24'h000000, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LHU:  data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: runs the data-bus handshake for loads/stores and registers the writeback bundle.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of aligning them.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic [31:0] ex_mem_instruction,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_load_data,
    output logic [31:0] wb_instruction,
    output logic [4:0]  wb_rd,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic        wb_mem_reg,
    output logic        wb_bus_err
);

    localparam int            CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

    mem_state_t    state_r;
    mem_state_t    state_nxt_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_cnt_nxt_s;

    logic [2:0]  ex_funct3_s;
    logic        mem_op_s;
    logic        misalign_s;
    logic        bus_op_s;
    logic        launch_s;
    logic        fire_s;
    logic        fire_err_s;
    logic        fire_bus_s;
    logic [31:0] load_data_s;

    logic [31:0] lat_addr_r;
    logic [31:0] lat_instr_r;
    logic [4:0]  lat_rd_r;
    logic        lat_read_r;
    logic        lat_reg_write_r;
    logic        lat_mem_reg_r;

    assign ex_funct3_s = ex_mem_instruction[14:12];
    assign mem_op_s    = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_s = mem_op_s & is_misaligned(ex_funct3_s, ex_alu_result[1:0]);
`else
    assign misalign_s = 1'b0;
`endif

    // A trapped access never reaches the bus, so it neither stalls nor launches.
    assign bus_op_s  = mem_op_s & ~misalign_s;
    assign mem_stall = ~rst & (((state_r == ST_IDLE) & bus_op_s) |
                               ((state_r == ST_WAIT) & ~dmem_ack));

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (lat_addr_r[1:0]),
        .funct3  (lat_instr_r[14:12]),
        .data    (load_data_s)
    );

    // Next-state and completion decode.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        launch_s       = 1'b0;
        fire_s         = 1'b0;
        fire_err_s     = 1'b0;
        fire_bus_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus_op_s) begin
                    launch_s       = 1'b1;
                    state_nxt_s    = ST_WAIT;
                    wait_cnt_nxt_s = {CW{1'b0}};
                end else begin
                    fire_s     = 1'b1;
                    fire_err_s = misalign_s;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    fire_s         = 1'b1;
                    fire_bus_s     = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = {CW{1'b0}};
                end else if (wait_cnt_r == LAST_WAIT) begin
                    fire_s         = 1'b1;
                    fire_bus_s     = 1'b1;
                    fire_err_s     = 1'b1;
                    state_nxt_s    = ST_IDLE;
                    wait_cnt_nxt_s = {CW{1'b0}};
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + CW'(1);
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                wait_cnt_nxt_s = {CW{1'b0}};
            end
        endcase
    end

    // FSM state and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Capture the access at launch; upstream is frozen but this keeps WAIT self-contained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr_r      <= 32'h0000_0000;
            lat_instr_r     <= 32'h0000_0000;
            lat_rd_r        <= 5'd0;
            lat_read_r      <= 1'b0;
            lat_reg_write_r <= 1'b0;
            lat_mem_reg_r   <= 1'b0;
        end else if (launch_s) begin
            lat_addr_r      <= ex_alu_result;
            lat_instr_r     <= ex_mem_instruction;
            lat_rd_r        <= ex_rd;
            lat_read_r      <= ex_mem_read & ~ex_mem_write;
            lat_reg_write_r <= ex_reg_write;
            lat_mem_reg_r   <= ex_mem_reg;
        end
    end

    // Data-bus request, held stable for the whole WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0000_0000;
            dmem_wdata <= 32'h0000_0000;
            dmem_be    <= 4'b0000;
        end else if (launch_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= {ex_alu_result[31:2], 2'b00};
            dmem_wdata <= ex_mem_write ? store_wdata(ex_funct3_s, ex_rs2_data) : 32'h0000_0000;
            dmem_be    <= ex_mem_write ? store_be(ex_funct3_s, ex_alu_result[1:0]) : 4'b1111;
        end else if (fire_bus_s) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0000_0000;
            dmem_wdata <= 32'h0000_0000;
            dmem_be    <= 4'b0000;
        end
    end

    // Writeback bundle; valid and bus_err are single-cycle strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid       <= 1'b0;
            wb_bus_err     <= 1'b0;
            wb_alu_result  <= 32'h0000_0000;
            wb_load_data   <= 32'h0000_0000;
            wb_instruction <= 32'h0000_0000;
            wb_rd          <= 5'd0;
            wb_reg_write   <= 1'b0;
            wb_mem_reg     <= 1'b0;
        end else begin
            wb_valid   <= fire_s;
            wb_bus_err <= fire_err_s;
            if (fire_s && fire_bus_s) begin
                wb_alu_result  <= lat_addr_r;
                wb_instruction <= lat_instr_r;
                wb_rd          <= lat_rd_r;
                wb_mem_reg     <= lat_mem_reg_r;
                wb_reg_write   <= lat_reg_write_r & ~fire_err_s;
                wb_load_data   <= (lat_read_r && !fire_err_s) ? load_data_s : 32'h0000_0000;
            end else if (fire_s) begin
                wb_alu_result  <= ex_alu_result;
                wb_instruction <= ex_mem_instruction;
                wb_rd          <= ex_rd;
                wb_mem_reg     <= ex_mem_reg;
                wb_reg_write   <= ex_reg_write & ~fire_err_s;
                wb_load_data   <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_mem_stage;

    localparam int MAX_WAIT = 16;

    logic        clk, rst;
    logic [31:0] ex_alu_result, ex_rs2_data, ex_mem_instruction;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_reg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack, mem_stall;
    logic [31:0] wb_alu_result, wb_load_data, wb_instruction;
    logic [4:0]  wb_rd;
    logic        wb_valid, wb_reg_write, wb_mem_reg, wb_bus_err;

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .ex_alu_result(ex_alu_result), .ex_rs2_data(ex_rs2_data),
        .ex_mem_instruction(ex_mem_instruction), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_reg(ex_mem_reg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .wb_instruction(wb_instruction), .wb_rd(wb_rd),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_mem_reg(wb_mem_reg), .wb_bus_err(wb_bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        valid;
        logic        err;
        logic        rw;
        logic        mr;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] instr;
        logic [31:0] load;
    } wb_t;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    logic        exp_stall, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    wb_t         exp_wb, pend;
    bit          pend_valid = 1'b0;

    int          obs_stall_cnt, obs_req_cnt;
    bit          obs_got;
    logic [31:0] obs_addr, obs_wdata, obs_wb_load, obs_wb_alu;
    logic [3:0]  obs_be;
    logic [4:0]  obs_wb_rd;
    logic        obs_wb_valid, obs_wb_err, obs_wb_rw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = (longint'(rd) >> (8 * int'(a[1:0]))) & 255;
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = (longint'(rd) >> (16 * int'(a[1]))) & 65535;
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(rd);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int lane;
        lane = int'(a[1:0]);
        if (f3 == 3'b000) return 4'(1 << lane);
        if (f3 == 3'b001) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'b000) return (d & 32'h0000_00FF) * 32'h0101_0101;
        if (f3 == 3'b001) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        if (f3 == 3'b010) return (a % 4) != 0;
        return 1'b0;
    endfunction

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
            chk("dmem_req", 32'(dmem_req), 32'(exp_req));
            if (exp_req) begin
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_we", 32'(dmem_we), 32'(exp_we));
                if (exp_we) begin
                    chk("dmem_be", 32'(dmem_be), 32'(exp_be));
                    chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            chk("wb_valid", 32'(wb_valid), 32'(exp_wb.valid));
            chk("wb_bus_err", 32'(wb_bus_err), 32'(exp_wb.err));
            if (exp_wb.valid) begin
                chk("wb_rd", 32'(wb_rd), 32'(exp_wb.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(exp_wb.rw));
                chk("wb_mem_reg", 32'(wb_mem_reg), 32'(exp_wb.mr));
                chk("wb_alu_result", wb_alu_result, exp_wb.alu);
                chk("wb_instruction", wb_instruction, exp_wb.instr);
                chk("wb_load_data", wb_load_data, exp_wb.load);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic begin_window();
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        if (pend_valid) begin
            exp_wb = pend;
        end else begin
            exp_wb.valid = 1'b0;
            exp_wb.err   = 1'b0;
        end
        pend_valid = 1'b0;
    endtask

    task automatic snap();
        #3;
        obs_stall_cnt += int'(mem_stall);
        obs_req_cnt   += int'(dmem_req);
        if (dmem_req && !obs_got) begin
            obs_got   = 1'b1;
            obs_addr  = dmem_addr;
            obs_be    = dmem_be;
            obs_wdata = dmem_wdata;
        end
        obs_wb_valid = wb_valid;
        obs_wb_err   = wb_bus_err;
        obs_wb_rw    = wb_reg_write;
        obs_wb_rd    = wb_rd;
        obs_wb_alu   = wb_alu_result;
        obs_wb_load  = wb_load_data;
    endtask

    task automatic clear_obs();
        obs_stall_cnt = 0;
        obs_req_cnt   = 0;
        obs_got       = 1'b0;
    endtask

    task automatic run_alu(input logic [4:0] rd, input logic rw, input logic [31:0] res, input logic mr);
        logic [31:0] instr;
        clear_obs();
        begin_window();
        instr              = $urandom;
        ex_alu_result      = res;
        ex_rs2_data        = $urandom;
        ex_mem_instruction = instr;
        ex_rd              = rd;
        ex_reg_write       = rw;
        ex_mem_reg         = mr;
        ex_mem_read        = 1'b0;
        ex_mem_write       = 1'b0;
        dmem_ack           = 1'($urandom_range(0, 1));
        dmem_rdata         = $urandom;
        exp_stall = 1'b0;
        exp_req   = 1'b0;
        pend.valid = 1'b1; pend.err = 1'b0; pend.rw = rw; pend.mr = mr;
        pend.rd = rd; pend.alu = res; pend.instr = instr; pend.load = 32'h0;
        pend_valid = 1'b1;
        snap();
    endtask

    // ack_at: WAIT cycle (1-based) carrying ack; beyond MAX_WAIT means no ack.
    task automatic run_mem(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rs2, input logic [4:0] rd, input logic rw,
                           input logic mr, input int ack_at, input logic [31:0] rdata,
                           input int rst_at);
        logic [31:0] instr;
        int          n;
        bit          tout;
        clear_obs();
        begin_window();
        instr              = $urandom;
        instr[14:12]       = f3;
        ex_alu_result      = a;
        ex_rs2_data        = rs2;
        ex_mem_instruction = instr;
        ex_rd              = rd;
        ex_reg_write       = rw;
        ex_mem_reg         = mr;
        ex_mem_read        = ~wr;
        ex_mem_write       = wr;
        dmem_ack           = 1'($urandom_range(0, 1));
        dmem_rdata         = $urandom;
        exp_req            = 1'b0;
        pend.rd = rd; pend.mr = mr; pend.alu = a; pend.instr = instr; pend.valid = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
        if (m_misaligned(f3, a)) begin
            exp_stall  = 1'b0;
            pend.err   = 1'b1;
            pend.rw    = 1'b0;
            pend.load  = 32'h0;
            pend_valid = 1'b1;
            snap();
            return;
        end
`endif
        exp_stall = 1'b1;
        snap();
        tout = (ack_at < 1 || ack_at > MAX_WAIT);
        n    = tout ? MAX_WAIT : ack_at;
        for (int w = 1; w <= n; w++) begin
            begin_window();
            dmem_ack   = (w == ack_at);
            dmem_rdata = (w == ack_at) ? rdata : $urandom;
            exp_req    = 1'b1;
            exp_we     = wr;
            exp_addr   = a - (a % 4);
            exp_be     = m_be(f3, a);
            exp_wdata  = m_wdata(f3, rs2);
            exp_stall  = (w != ack_at);
            if (w == rst_at) begin
                chk_en = 1'b0;
                #1 rst = 1'b1;
                #1;
                chk("rst_dmem_req", 32'(dmem_req), 32'h0);
                chk("rst_mem_stall", 32'(mem_stall), 32'h0);
                chk("rst_dmem_we", 32'(dmem_we), 32'h0);
                chk("rst_dmem_addr", dmem_addr, 32'h0);
                chk("rst_dmem_be", 32'(dmem_be), 32'h0);
                chk("rst_wb_valid", 32'(wb_valid), 32'h0);
                chk("rst_wb_bus_err", 32'(wb_bus_err), 32'h0);
                chk("rst_wb_alu", wb_alu_result, 32'h0);
                return;
            end
            snap();
        end
        pend.err   = tout;
        pend.rw    = tout ? 1'b0 : rw;
        pend.load  = (!wr && !tout) ? m_load(f3, a, rdata) : 32'h0;
        pend_valid = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [2:0] lf3 [5];
        logic [2:0] sf3 [3];
        lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
        sf3[0] = 3'b000; sf3[1] = 3'b001; sf3[2] = 3'b010;

        rst = 1'b1;
        ex_alu_result = 32'h0; ex_rs2_data = 32'h0; ex_mem_instruction = 32'h0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_write = 1'b0; ex_mem_reg = 1'b0;
        ex_mem_read = 1'b1;
        dmem_rdata = 32'h0; dmem_ack = 1'b0;
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
        exp_wb.valid = 1'b0; exp_wb.err = 1'b0;
        #2;
        chk("reset_dmem_req", 32'(dmem_req), 32'h0);
        chk("reset_mem_stall", 32'(mem_stall), 32'h0);
        chk("reset_wb_valid", 32'(wb_valid), 32'h0);
        chk("reset_wb_bus_err", 32'(wb_bus_err), 32'h0);
        chk("reset_dmem_addr", dmem_addr, 32'h0);

        // ALU op, latency 1, no stall.
        run_alu(5'd5, 1'b1, 32'h0000_1234, 1'b0);
        chk("alu_stall_cnt", 32'(obs_stall_cnt), 32'd0);
        run_alu(5'd1, 1'b0, 32'h0, 1'b0);
        chk("alu_wb_valid", 32'(obs_wb_valid), 32'd1);
        chk("alu_wb_rd", 32'(obs_wb_rd), 32'd5);
        chk("alu_wb_result", obs_wb_alu, 32'h0000_1234);

        // SB with ack on the third WAIT cycle.
        run_mem(1'b1, 3'b000, 32'h0000_0103, 32'hAABB_CCDD, 5'd0, 1'b0, 1'b0, 3, 32'h0, 0);
        chk("sb_addr", obs_addr, 32'h0000_0100);
        chk("sb_be", 32'(obs_be), 32'h8);
        chk("sb_wdata", obs_wdata, 32'hDDDD_DDDD);
        chk("sb_stall_cycles", 32'(obs_stall_cnt), 32'd3);

        // LB / LBU from lane 2, minimum latency.
        run_mem(1'b0, 3'b000, 32'h0000_0102, 32'h0, 5'd3, 1'b1, 1'b1, 1, 32'h0080_0000, 0);
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        chk("lb_load", obs_wb_load, 32'hFFFF_FF80);
        run_mem(1'b0, 3'b100, 32'h0000_0102, 32'h0, 5'd3, 1'b1, 1'b1, 2, 32'h0080_0000, 0);
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        chk("lbu_load", obs_wb_load, 32'h0000_0080);

        // Timeout with no ack.
        run_mem(1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b1, MAX_WAIT + 10, 32'h0, 0);
        chk("tout_req_cycles", 32'(obs_req_cnt), 32'(MAX_WAIT));
        chk("tout_stall_cycles", 32'(obs_stall_cnt), 32'(MAX_WAIT + 1));
        run_alu(5'd2, 1'b1, 32'h0000_0777, 1'b0);
        chk("tout_bus_err", 32'(obs_wb_err), 32'd1);
        chk("tout_reg_write", 32'(obs_wb_rw), 32'd0);
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        chk("tout_err_one_cycle", 32'(obs_wb_err), 32'd0);

        // Ack on the last allowed WAIT cycle wins over timeout.
        run_mem(1'b0, 3'b010, 32'h0000_0080, 32'h0, 5'd4, 1'b1, 1'b1, MAX_WAIT, 32'hCAFE_F00D, 0);
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        chk("edge_ack_err", 32'(obs_wb_err), 32'd0);
        chk("edge_ack_load", obs_wb_load, 32'hCAFE_F00D);

        // Misaligned LW.
        run_mem(1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd6, 1'b1, 1'b1, 2, 32'h1122_3344, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req_cycles", 32'(obs_req_cnt), 32'd0);
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        chk("mis_bus_err", 32'(obs_wb_err), 32'd1);
        chk("mis_reg_write", 32'(obs_wb_rw), 32'd0);
`else
        chk("mis_addr", obs_addr, 32'h0000_0100);
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        chk("mis_load", obs_wb_load, 32'h1122_3344);
`endif

        // Reset in the middle of WAIT.
        run_mem(1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd8, 1'b1, 1'b0, 10, 32'h0, 3);
        run_alu(5'd9, 1'b1, 32'h0000_0055, 1'b0);
        chk("post_rst_stall", 32'(obs_stall_cnt), 32'd0);
        chk("post_rst_no_wb", 32'(obs_wb_valid), 32'd0);
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        chk("post_rst_alu_rd", 32'(obs_wb_rd), 32'd9);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            int          kind, ack_at;
            logic [31:0] a;
            kind   = $urandom_range(0, 2);
            a      = $urandom;
            ack_at = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 4) : $urandom_range(1, MAX_WAIT + 3);
            if (kind == 0) begin
                run_alu(5'($urandom), 1'($urandom), $urandom, 1'($urandom));
            end else if (kind == 1) begin
                run_mem(1'b0, lf3[$urandom_range(0, 4)], a, $urandom, 5'($urandom), 1'b1,
                        1'b1, ack_at, $urandom, 0);
            end else begin
                run_mem(1'b1, sf3[$urandom_range(0, 2)], a, $urandom, 5'($urandom), 1'b0,
                        1'b0, ack_at, $urandom, 0);
            end
        end
        run_alu(5'd0, 1'b0, 32'h0, 1'b0);
        begin_window();
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
        exp_stall    = 1'b0;
        exp_req      = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
